agu_seq: RTL and testbench

Sequenced, parametrised address generation unit for the load/store unit. It accepts one memory instruction per warp: base register, immediate, stride, addressing mode, warp number and thread mask. It then issues the per-thread addresses to the memory port in beats of `PORTS` lanes, using a valid/ready handshake. Beats with no active lanes are skipped, and the unit flags address overflow. It sits between the warp scheduler / register-file read stage and the memory request path inside the LSU.

---
 rtl/agu_seq_if.sv | 34 +++
 rtl/agu_seq.sv | 106 ++++++++++
 tb/tb_agu_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/agu_seq_if.sv
// agu_seq_if: request bus from the scheduler and beat bus to the memory port of agu_seq
interface agu_seq_if #(
  parameter int THREADS = 8,
  parameter int PORTS = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int WARP_BITS = 2
);
  localparam int BEAT_BITS = THREADS / PORTS > 1 ? $clog2(THREADS / PORTS) : 1;
  logic req_valid;
  logic req_ready;
  logic [1:0] req_mode;
  logic [DATA_WIDTH-1:0] req_base_reg;
  logic [3:0] req_base_imm;
  logic [DATA_WIDTH-1:0] req_stride;
  logic [WARP_BITS-1:0] req_warp;
  logic [THREADS-1:0] req_mask;
  logic mem_valid;
  logic mem_ready;
  logic [PORTS*ADDR_WIDTH-1:0] mem_addr;
  logic [PORTS-1:0] mem_lane_mask;
  logic [BEAT_BITS-1:0] mem_beat;
  logic mem_last;
  logic mem_ovf;
  logic done;
  modport master (
    output req_valid, req_mode, req_base_reg, req_base_imm, req_stride, req_warp, req_mask, mem_ready,
    input req_ready, mem_valid, mem_addr, mem_lane_mask, mem_beat, mem_last, mem_ovf, done
  );
  modport slave (
    input req_valid, req_mode, req_base_reg, req_base_imm, req_stride, req_warp, req_mask, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_lane_mask, mem_beat, mem_last, mem_ovf, done
  );
endinterface

// File: rtl/agu_seq.sv
// agu_seq: sequenced address generation unit issuing per-thread addresses in PORTS-wide beats
module agu_seq #(
  parameter int THREADS = 8,
  parameter int PORTS = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int WARP_BITS = 2
) (
  input logic clk,
  input logic reset,
  agu_seq_if.slave bus
);
  localparam int BEATS = THREADS / PORTS;
  localparam int BB = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int SW = DATA_WIDTH + 2;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_n;
  logic idle, accept, fire, load, last_n, done_n;
  logic [1:0] mode_q, s_mode;
  logic [DATA_WIDTH-1:0] base_q, stride_q, s_base, s_stride;
  logic [3:0] imm_q, s_imm;
  logic [WARP_BITS-1:0] warp_q, s_warp;
  logic [THREADS-1:0] mask_q, s_mask;
  logic [BB-1:0] beat_q, nb;
  logic [BEATS-1:0] beat_any;
  logic [PORTS-1:0] lm, lane_ovf;
  logic [PORTS*ADDR_WIDTH-1:0] addr_n;
  assign idle = state == IDLE;
  assign accept = idle && bus.req_valid;
  assign fire = !idle && bus.mem_ready;
  assign s_mode = idle ? bus.req_mode : mode_q;
  assign s_base = idle ? bus.req_base_reg : base_q;
  assign s_imm = idle ? bus.req_base_imm : imm_q;
  assign s_stride = idle ? bus.req_stride : stride_q;
  assign s_warp = idle ? bus.req_warp : warp_q;
  assign s_mask = idle ? bus.req_mask : mask_q;
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    assign beat_any[b] = |s_mask[b*PORTS +: PORTS];
  end
  always_comb begin
    nb = '0;
    last_n = 1'b1;
    for (int b = BEATS - 1; b >= 0; b--)
      if (beat_any[b] && (idle || BB'(b) > beat_q)) nb = BB'(b);
    for (int b = 0; b < BEATS; b++)
      if (beat_any[b] && BB'(b) > nb) last_n = 1'b0;
  end
  assign lm = PORTS'(s_mask >> (PORTS * int'(nb)));
  // Two spare sum bits hold the carry out of base+imm+offset for overflow detection.
  for (genvar j = 0; j < PORTS; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] t, off;
    logic [SW-1:0] sum;
    assign t = DATA_WIDTH'(nb) * DATA_WIDTH'(PORTS) + DATA_WIDTH'(j);
    assign off = s_mode == 2'd0 ? t :
                 s_mode == 2'd1 ? t * s_stride :
                 s_mode == 2'd2 ? '0 :
                 (DATA_WIDTH'(s_warp) * DATA_WIDTH'(THREADS) + t) * s_stride;
    assign sum = SW'(s_base) + SW'(s_imm) + SW'(off);
    assign lane_ovf[j] = |sum[SW-1:ADDR_WIDTH];
    assign addr_n[j*ADDR_WIDTH +: ADDR_WIDTH] = lm[j] ? sum[ADDR_WIDTH-1:0] : '0;
  end
  always_comb begin
    state_n = accept && |bus.req_mask ? ISSUE : fire && bus.mem_last ? IDLE : state;
    load = accept ? |bus.req_mask : fire && !bus.mem_last;
    done_n = accept ? ~|bus.req_mask : fire && bus.mem_last;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= '0;
      base_q <= '0;
      imm_q <= '0;
      stride_q <= '0;
      warp_q <= '0;
      mask_q <= '0;
      beat_q <= '0;
      bus.mem_addr <= '0;
      bus.mem_lane_mask <= '0;
      bus.mem_last <= 1'b0;
      bus.mem_ovf <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= bus.req_mode;
        base_q <= bus.req_base_reg;
        imm_q <= bus.req_base_imm;
        stride_q <= bus.req_stride;
        warp_q <= bus.req_warp;
        mask_q <= bus.req_mask;
      end
      if (load) begin
        beat_q <= nb;
        bus.mem_addr <= addr_n;
        bus.mem_lane_mask <= lm;
        bus.mem_last <= last_n;
        bus.mem_ovf <= |(lane_ovf & lm);
      end
      bus.done <= done_n;
    end
  end
  assign bus.req_ready = idle;
  assign bus.mem_valid = !idle;
  assign bus.mem_beat = beat_q;
endmodule

// File: tb/tb_agu_seq.sv
// tb_agu_seq: table vectors, hand-written corner sequences and randomized requests for agu_seq,
// checked cycle by cycle against a per-thread arithmetic model of the address rules.
module tb_agu_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  agu_seq_if #(.THREADS(8), .PORTS(2), .DATA_WIDTH(16), .ADDR_WIDTH(8), .WARP_BITS(2)) bus ();
  agu_seq #(.THREADS(8), .PORTS(2), .DATA_WIDTH(16), .ADDR_WIDTH(8), .WARP_BITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0] beat;
    logic [1:0] lm;
    logic [15:0] addr;
    logic last;
    logic ovf;
  } beat_t;

  typedef struct {
    int nbeats;
    logic [3:0] map;
    logic [15:0] first;
    logic [15:0] last;
    logic [3:0] ovf_map;
    int done_cyc;
  } obs_t;

  typedef struct {
    logic [1:0] mode;
    logic [15:0] base;
    logic [3:0] imm;
    logic [15:0] stride;
    logic [1:0] warp;
    logic [7:0] mask;
    int nbeats;
    logic [3:0] map;
    logic [15:0] first;
    logic [15:0] last;
    logic [3:0] ovf_map;
  } vec_t;

  localparam int NV = 10;
  int n_cmp = 0;
  int n_bad = 0;
  beat_t exp_q[$];
  logic [31:0] idle_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_word();
    return {7'd0, bus.mem_valid, bus.done, bus.req_ready, bus.mem_beat, bus.mem_lane_mask,
            bus.mem_addr, bus.mem_last, bus.mem_ovf};
  endfunction

  // Expected beat list: per-thread address arithmetic, empty beats dropped.
  task automatic model(input logic [1:0] mode, input logic [15:0] base, input logic [3:0] imm,
                       input logic [15:0] stride, input logic [1:0] warp, input logic [7:0] mask);
    exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      beat_t e;
      e = '0;
      e.beat = 2'(b);
      for (int j = 0; j < 2; j++) begin
        int t;
        longint off, s;
        t = b * 2 + j;
        if (mask[t]) begin
          case (mode)
            2'd0: off = longint'(t);
            2'd1: off = longint'(t) * longint'(stride);
            2'd2: off = 0;
            default: off = (longint'(warp) * 8 + longint'(t)) * longint'(stride);
          endcase
          s = longint'(base) + longint'(imm) + off % 65536;
          e.lm[j] = 1'b1;
          e.addr[j*8 +: 8] = 8'(s);
          e.ovf = e.ovf | (s > 255);
        end
      end
      if (e.lm != 2'b00) exp_q.push_back(e);
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  task automatic run_req(input logic [1:0] mode, input logic [15:0] base, input logic [3:0] imm,
                         input logic [15:0] stride, input logic [1:0] warp, input logic [7:0] mask,
                         input int stall_beat, input int stall_n, input bit rnd, input int abort_beat,
                         output obs_t o);
    int k, c, stalls;
    logic rdy;
    k = 0;
    c = 1;
    stalls = 0;
    model(mode, base, imm, stride, warp, mask);
    o = '{nbeats: 0, map: '0, first: '0, last: '0, ovf_map: '0, done_cyc: 0};
    check("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_mode = mode;
    bus.req_base_reg = base;
    bus.req_base_imm = imm;
    bus.req_stride = stride;
    bus.req_warp = warp;
    bus.req_mask = mask;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_mode = 2'($urandom);
    bus.req_base_reg = 16'($urandom);
    bus.req_base_imm = 4'($urandom);
    bus.req_stride = 16'($urandom);
    bus.req_warp = 2'($urandom);
    bus.req_mask = 8'($urandom);
    while (1) begin
      if (k == exp_q.size()) begin
        check("done", 32'({bus.mem_valid, bus.done, bus.req_ready}), 32'b011);
        o.done_cyc = c;
        break;
      end
      check("beat", dut_word(), {7'd0, 3'b100, exp_q[k]});
      if (k == abort_beat) begin
        reset = 1'b0;
        #1;
        check("rst_out", dut_word(), idle_word);
        repeat (2) begin
          @(posedge clk); #1;
          check("rst_hold", dut_word(), idle_word);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst", 32'({bus.mem_valid, bus.done, bus.req_ready}), 32'b001);
        return;
      end
      if (k == stall_beat && stalls < stall_n) begin
        rdy = 1'b0;
        stalls++;
      end else rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.mem_ready = rdy;
      if (rdy) begin
        if (o.nbeats == 0) o.first = bus.mem_addr;
        o.last = bus.mem_addr;
        o.map[bus.mem_beat] = 1'b1;
        o.ovf_map[bus.mem_beat] = bus.mem_ovf;
        o.nbeats++;
        k++;
      end
      @(posedge clk); #1;
      c++;
      if (c > 200) begin
        check("timeout", 32'(c), 32'd200);
        break;
      end
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v[NV];
    obs_t o;
    logic [15:0] rb, rs;
    idle_word = {7'd0, 3'b001, 22'd0};
    bus.req_valid = 1'b0;
    bus.req_mode = '0;
    bus.req_base_reg = '0;
    bus.req_base_imm = '0;
    bus.req_stride = '0;
    bus.req_warp = '0;
    bus.req_mask = '0;
    bus.mem_ready = 1'b0;
    #12;
    check("reset_state", dut_word(), idle_word);
    reset = 1'b1;
    @(posedge clk); #1;

    v[0] = '{2'd0, 16'h0010, 4'd3, 16'd0, 2'd0, 8'hFF, 4, 4'b1111, 16'h1413, 16'h1A19, 4'b0000};
    v[1] = '{2'd1, 16'h0020, 4'd0, 16'd4, 2'd0, 8'h81, 2, 4'b1001, 16'h0020, 16'h3C00, 4'b0000};
    v[2] = '{2'd3, 16'h0000, 4'd0, 16'd1, 2'd2, 8'hFF, 4, 4'b1111, 16'h1110, 16'h1716, 4'b0000};
    v[3] = '{2'd2, 16'h0055, 4'd0, 16'd9, 2'd1, 8'hFF, 4, 4'b1111, 16'h5555, 16'h5555, 4'b0000};
    v[4] = '{2'd0, 16'h00FC, 4'd0, 16'd0, 2'd0, 8'hFF, 4, 4'b1111, 16'hFDFC, 16'h0302, 4'b1100};
    v[5] = '{2'd0, 16'h00FC, 4'd0, 16'd0, 2'd0, 8'h0F, 2, 4'b0011, 16'hFDFC, 16'hFFFE, 4'b0000};
    v[6] = '{2'd0, 16'h0010, 4'd3, 16'd0, 2'd0, 8'h00, 0, 4'b0000, 16'h0000, 16'h0000, 4'b0000};
    v[7] = '{2'd1, 16'hFFFF, 4'd1, 16'd0, 2'd0, 8'h01, 1, 4'b0001, 16'h0000, 16'h0000, 4'b0001};
    v[8] = '{2'd0, 16'h0000, 4'd0, 16'd0, 2'd0, 8'h40, 1, 4'b1000, 16'h0006, 16'h0006, 4'b0000};
    v[9] = '{2'd1, 16'h0000, 4'd0, 16'h8000, 2'd0, 8'h0C, 1, 4'b0010, 16'h0000, 16'h0000, 4'b0010};

    for (int i = 0; i < NV; i++) begin
      run_req(v[i].mode, v[i].base, v[i].imm, v[i].stride, v[i].warp, v[i].mask, -1, 0, 1'b0, -1, o);
      check($sformatf("v%0d_nbeats", i), 32'(o.nbeats), 32'(v[i].nbeats));
      check($sformatf("v%0d_map", i), 32'(o.map), 32'(v[i].map));
      check($sformatf("v%0d_first", i), 32'(o.first), 32'(v[i].first));
      check($sformatf("v%0d_last", i), 32'(o.last), 32'(v[i].last));
      check($sformatf("v%0d_ovf", i), 32'(o.ovf_map), 32'(v[i].ovf_map));
      check($sformatf("v%0d_done_cyc", i), 32'(o.done_cyc), 32'(v[i].nbeats + 1));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
    end

    run_req(2'd0, 16'h0010, 4'd3, 16'd0, 2'd0, 8'hFF, 1, 3, 1'b0, -1, o);
    check("bp_done_cyc", 32'(o.done_cyc), 32'd8);
    check("bp_nbeats", 32'(o.nbeats), 32'd4);
    check("bp_last", 32'(o.last), 32'h1A19);

    run_req(2'd0, 16'h0010, 4'd3, 16'd0, 2'd0, 8'hFF, -1, 0, 1'b0, 2, o);
    check("abort_nbeats", 32'(o.nbeats), 32'd2);
    run_req(2'd0, 16'h0010, 4'd3, 16'd0, 2'd0, 8'hFF, -1, 0, 1'b0, -1, o);
    check("after_rst_first", 32'(o.first), 32'h1413);
    check("after_rst_last", 32'(o.last), 32'h1A19);
    check("after_rst_done_cyc", 32'(o.done_cyc), 32'd5);

    for (int r = 0; r < 80; r++) begin
      rb = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      rs = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      run_req(2'($urandom), rb, 4'($urandom), rs, 2'($urandom),
              ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1, -1, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
